mem_arbiter: RTL and testbench

//  Shares the core's single-port memory between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_grant.sv | 38 +++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state, port and bus types for the IF/LS memory arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_IF,
        ARB_PORT_LS
    } arb_port_t;

    typedef logic [ADDR_W_DEF-1:0]   addr_t;
    typedef logic [DATA_W_DEF-1:0]   data_t;
    typedef logic [DATA_W_DEF/8-1:0] byte_en_t;

    function automatic logic latency_legal(input int lat);
        return lat >= 1 && lat <= 15;
    endfunction

endpackage

// File: rtl/mem_arbiter_grant.sv
// mem_arbiter_grant: picks IF or LS for the next access; round-robin when MEM_ARB_FAIR_EN is defined, else LS priority
module mem_arbiter_grant
    import mem_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      if_valid,
    input  logic      ls_valid,
    input  logic      accept,
    output arb_port_t grant
);

`ifdef MEM_ARB_FAIR_EN
    arb_port_t last_grant;

    always_ff @(posedge clk) begin
        if (!reset)
            last_grant <= ARB_PORT_IF;
        else if (accept)
            last_grant <= grant;
    end

    // on a tie, favour whichever port did not win the previous grant
    always_comb begin
        grant = ls_valid ? ARB_PORT_LS : ARB_PORT_IF;
        grant = (if_valid && ls_valid) ? (last_grant == ARB_PORT_IF ? ARB_PORT_LS : ARB_PORT_IF) : grant;
    end
`else
    logic unused_fair;

    assign unused_fair = clk ^ reset ^ accept ^ if_valid;

    always_comb begin
        grant = ls_valid ? ARB_PORT_LS : ARB_PORT_IF;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between IF and LS (MEM_ARB_FAIR_EN selects round-robin over LS priority)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    if (!latency_legal(MEM_LATENCY)) begin : g_bad_latency
        $error("mem_arbiter: MEM_LATENCY must be within 1..15");
    end

    arb_state_t        state, state_nx;
    arb_port_t         grant, owner;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic [BE_W-1:0]   be_r;
    logic [DATA_W-1:0] wdata_r, if_rdata_r, ls_rdata_r;
    logic              idle, accept, grant_ls, access, last_cyc;
    logic              unused_bits;

    assign unused_bits = ^{if_addr[1:0], ls_addr[1:0]};

    // ready is masked while reset is asserted so no handshake completes during reset
    assign idle     = state == ARB_IDLE && reset;
    assign grant_ls = grant == ARB_PORT_LS;
    assign accept   = if_req_ready || ls_req_ready;
    assign access   = state == ARB_ACCESS;
    assign last_cyc = cnt == 4'(MEM_LATENCY - 1);

    mem_arbiter_grant u_grant (
        .clk      (clk),
        .reset    (reset),
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .accept   (accept),
        .grant    (grant)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= ARB_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        state_nx     = state == ARB_IDLE ? (accept ? ARB_ACCESS : ARB_IDLE)
                     : state == ARB_ACCESS ? (last_cyc ? ARB_RESP : ARB_ACCESS)
                     : ARB_IDLE;
        if_req_ready = idle && if_req_valid && !grant_ls;
        ls_req_ready = idle && ls_req_valid && grant_ls;
        mem_en       = access;
        mem_we       = access && we_r;
        mem_be       = access ? be_r : '0;
        mem_addr     = access ? addr_r : '0;
        mem_wdata    = access ? wdata_r : '0;
        if_rsp_valid = state == ARB_RESP && owner == ARB_PORT_IF;
        ls_rsp_valid = state == ARB_RESP && owner == ARB_PORT_LS;
        if_rdata     = if_rdata_r;
        ls_rdata     = ls_rdata_r;
        busy         = state != ARB_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner      <= ARB_PORT_IF;
            cnt        <= '0;
            addr_r     <= '0;
            we_r       <= 1'b0;
            be_r       <= '0;
            wdata_r    <= '0;
            if_rdata_r <= '0;
            ls_rdata_r <= '0;
        end else begin
            if (accept) begin
                owner   <= grant;
                addr_r  <= grant_ls ? {ls_addr[ADDR_W-1:2], 2'b00} : {if_addr[ADDR_W-1:2], 2'b00};
                we_r    <= grant_ls && ls_we;
                be_r    <= (grant_ls && ls_we) ? ls_be : '1;
                wdata_r <= grant_ls ? ls_wdata : '0;
            end
            // read data lands in the owner's register on the edge that enters RESP
            if (access) begin
                cnt <= last_cyc ? '0 : cnt + 4'd1;
                if (last_cyc && owner == ARB_PORT_IF)
                    if_rdata_r <= mem_rdata;
                if (last_cyc && owner == ARB_PORT_LS)
                    ls_rdata_r <= we_r ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter against a word-level memory reference model
module tb_mem_arbiter;

    localparam int LAT = 3;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct {
        int          wait_c;
        int          lat;
        int          ens;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          stable;
        logic [31:0] rdata;
        bit          other_rsp;
        logic        rsp_after;
        logic [31:0] rdata_after;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rdata;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic [31:0] ls_addr = '0;
    logic        ls_we = 1'b0;
    logic [3:0]  ls_be = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_rsp_valid;
    logic [31:0] ls_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit last_ls = 1'b0;
    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    logic        mem_loaded = 1'b0;

    wire [138:0] all_outs = {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_en, mem_we,
                             mem_be, mem_addr, mem_wdata, if_rdata, ls_rdata, busy};

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_be(ls_be), .ls_wdata(ls_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // memory macro stand-in: combinational read, byte-masked write
    always @(posedge clk) begin
        if (!mem_loaded)
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
        else if (mem_en && mem_we)
            mem_arr[mem_addr[9:2]] <= merge(mem_arr[mem_addr[9:2]], mem_be, mem_wdata);
    end
    assign mem_rdata = mem_arr[mem_addr[9:2]];

    task automatic do_reset();
        reset = 1'b0;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        last_ls = 1'b0;
    endtask

    task automatic txn(input bit is_ls, input bit we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, output obs_t o);
        bit rdy = 1'b0;
        o = '{default: 0};
        o.stable = 1'b1;
        if (is_ls) begin
            ls_req_valid = 1'b1; ls_addr = a; ls_we = we; ls_be = be; ls_wdata = d;
        end else begin
            if_req_valid = 1'b1; if_addr = a;
        end
        while (!rdy && o.wait_c < 20) begin
            @(negedge clk);
            rdy = is_ls ? ls_req_ready : if_req_ready;
            if (!rdy) o.wait_c++;
        end
        @(posedge clk); #1;
        if (is_ls) ls_req_valid = 1'b0;
        else if_req_valid = 1'b0;
        if (!rdy) begin
            o.wait_c = -1;
            return;
        end
        last_ls = is_ls;
        for (int k = 1; k <= 4 * LAT + 8 && o.lat == 0; k++) begin
            @(negedge clk);
            if (mem_en) begin
                if (o.ens == 0) begin
                    o.addr = mem_addr; o.we = mem_we; o.be = mem_be; o.wdata = mem_wdata;
                end else if ({mem_addr, mem_we, mem_be, mem_wdata} !== {o.addr, o.we, o.be, o.wdata})
                    o.stable = 1'b0;
                o.ens++;
            end
            if (is_ls ? if_rsp_valid : ls_rsp_valid) o.other_rsp = 1'b1;
            if (is_ls ? ls_rsp_valid : if_rsp_valid) begin
                o.lat = k;
                o.rdata = is_ls ? ls_rdata : if_rdata;
            end
        end
        @(negedge clk);
        o.rsp_after = is_ls ? ls_rsp_valid : if_rsp_valid;
        o.rdata_after = is_ls ? ls_rdata : if_rdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_we = 1'b1; ls_be = 4'hf;
        @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL reset_hold outs=%h want 0", all_outs); end
        @(posedge clk); #1;
        if_req_valid = 1'b0; ls_req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL reset_idle outs=%h want 0", all_outs); end
        @(posedge clk); #1;
    endtask

    task automatic test_if_read();
        obs_t o;
        logic [31:0] exp = ref_mem[65];
        txn(1'b0, 1'b0, 32'h0000_0104, 4'h0, 32'h0, o);
        n_tests++;
        if (o.wait_c !== 0) begin n_fail++; $display("FAIL if_read_accept wait=%0d want 0", o.wait_c); end
        n_tests++;
        if (o.lat !== LAT + 1 || o.ens !== LAT) begin
            n_fail++; $display("FAIL if_read_timing lat=%0d ens=%0d want %0d/%0d", o.lat, o.ens, LAT + 1, LAT);
        end
        n_tests++;
        if (o.addr !== 32'h104 || o.we !== 1'b0 || o.be !== 4'hf || !o.stable) begin
            n_fail++; $display("FAIL if_read_bus addr=%h we=%b be=%b stable=%0d want 104/0/1111/1", o.addr, o.we, o.be, o.stable);
        end
        n_tests++;
        if (o.rdata !== exp) begin n_fail++; $display("FAIL if_read_data got %h want %h", o.rdata, exp); end
        n_tests++;
        if (o.other_rsp || o.rsp_after !== 1'b0 || o.rdata_after !== exp) begin
            n_fail++; $display("FAIL if_read_pulse other=%0d after=%b held=%h want 0/0/%h", o.other_rsp, o.rsp_after, o.rdata_after, exp);
        end
    endtask

    task automatic test_ls_store();
        obs_t o;
        logic [31:0] exp;
        txn(1'b1, 1'b1, 32'h0000_0200, 4'b0011, 32'hDEAD_BEEF, o);
        ref_mem[128] = merge(ref_mem[128], 4'b0011, 32'hDEAD_BEEF);
        n_tests++;
        if (o.lat !== LAT + 1 || o.ens !== LAT) begin
            n_fail++; $display("FAIL store_timing lat=%0d ens=%0d want %0d/%0d", o.lat, o.ens, LAT + 1, LAT);
        end
        n_tests++;
        if (o.addr !== 32'h200 || o.we !== 1'b1 || o.be !== 4'b0011 || o.wdata !== 32'hDEAD_BEEF || !o.stable) begin
            n_fail++; $display("FAIL store_bus addr=%h we=%b be=%b wdata=%h want 200/1/0011/deadbeef", o.addr, o.we, o.be, o.wdata);
        end
        n_tests++;
        if (o.rdata !== 32'h0 || o.other_rsp) begin
            n_fail++; $display("FAIL store_rsp rdata=%h other=%0d want 0/0", o.rdata, o.other_rsp);
        end
        exp = ref_mem[128];
        txn(1'b0, 1'b0, 32'h0000_0200, 4'h0, 32'h0, o);
        n_tests++;
        if (o.rdata !== exp) begin n_fail++; $display("FAIL store_readback got %h want %h", o.rdata, exp); end
        txn(1'b1, 1'b0, 32'h0000_0202, 4'h0, 32'h0, o);
        n_tests++;
        if (o.rdata !== exp || o.we !== 1'b0 || o.be !== 4'hf) begin
            n_fail++; $display("FAIL ls_load got %h we=%b be=%b want %h/0/1111", o.rdata, o.we, o.be, exp);
        end
    endtask

    task automatic test_align_withdraw();
        obs_t o;
        bit rdy = 1'b0, if_rdy_seen = 1'b0;
        int wait_c = 0, ens = 0, if_rsp_n = 0, ls_rsp_n = 0;
        txn(1'b0, 1'b0, 32'h0000_0107, 4'h0, 32'h0, o);
        n_tests++;
        if (o.addr !== 32'h104 || o.rdata !== ref_mem[65]) begin
            n_fail++; $display("FAIL align addr=%h data=%h want 104/%h", o.addr, o.rdata, ref_mem[65]);
        end
        ls_req_valid = 1'b1; ls_addr = 32'h40; ls_we = 1'b0;
        while (!rdy && wait_c < 20) begin
            @(negedge clk);
            rdy = ls_req_ready;
            wait_c++;
        end
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        if_req_valid = 1'b1; if_addr = 32'h300;
        for (int k = 1; k <= LAT + 8; k++) begin
            @(negedge clk);
            if (if_req_ready) if_rdy_seen = 1'b1;
            if (mem_en) ens++;
            if (if_rsp_valid) if_rsp_n++;
            if (ls_rsp_valid) ls_rsp_n++;
            @(posedge clk); #1;
            if (k == LAT) if_req_valid = 1'b0;
        end
        n_tests++;
        if (!rdy || if_rdy_seen || ens !== LAT || if_rsp_n !== 0 || ls_rsp_n !== 1) begin
            n_fail++;
            $display("FAIL withdraw acc=%0d if_ready=%0d ens=%0d if_rsp=%0d ls_rsp=%0d want 1/0/%0d/0/1",
                     rdy, if_rdy_seen, ens, if_rsp_n, ls_rsp_n, LAT);
        end
    endtask

    task automatic test_contention();
        int grants = 0, cyc = 0, last_cyc = 0, if_rsp_n = 0, ls_rsp_n = 0, if_acc = 0, ls_acc = 0;
        bit exp_ls, both = 1'b0, late_if = 1'b0;
        do_reset();
        if_req_valid = 1'b1; if_addr = $urandom & 32'h3fc;
        ls_req_valid = 1'b1; ls_addr = $urandom & 32'h3fc; ls_we = 1'b0;
        while (grants < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (if_rsp_valid) if_rsp_n++;
            if (ls_rsp_valid) ls_rsp_n++;
            if (if_req_ready && ls_req_ready) both = 1'b1;
            if (if_req_ready || ls_req_ready) begin
                exp_ls = FAIR ? !last_ls : 1'b1;
                n_tests++;
                if (ls_req_ready !== exp_ls) begin
                    n_fail++; $display("FAIL contend_grant%0d ls=%b want %b", grants, ls_req_ready, exp_ls);
                end
                if (grants > 0) begin
                    n_tests++;
                    if (cyc - last_cyc != LAT + 2) begin
                        n_fail++; $display("FAIL contend_gap%0d got %0d want %0d", grants, cyc - last_cyc, LAT + 2);
                    end
                end
                last_cyc = cyc;
                last_ls = ls_req_ready;
                grants++;
                if (ls_req_ready) ls_acc++;
                else if_acc++;
                @(posedge clk); #1;
                if (last_ls) ls_addr = $urandom & 32'h3fc;
                else if_addr = $urandom & 32'h3fc;
            end
        end
        n_tests++;
        if (grants != 4) begin n_fail++; $display("FAIL contend_count got %0d want 4", grants); end
        ls_req_valid = 1'b0;
        for (int k = 0; k < 20 && !late_if; k++) begin
            @(negedge clk);
            cyc++;
            if (if_rsp_valid) if_rsp_n++;
            if (ls_rsp_valid) ls_rsp_n++;
            if (if_req_ready) begin
                late_if = 1'b1;
                if_acc++;
                n_tests++;
                if (cyc - last_cyc != LAT + 2) begin
                    n_fail++; $display("FAIL pending_if_gap got %0d want %0d", cyc - last_cyc, LAT + 2);
                end
            end
            @(posedge clk); #1;
        end
        if_req_valid = 1'b0;
        n_tests++;
        if (!late_if) begin n_fail++; $display("FAIL pending_if_accept got 0 want 1"); end
        for (int k = 0; k < 2 * LAT + 6; k++) begin
            @(negedge clk);
            if (if_rsp_valid) if_rsp_n++;
            if (ls_rsp_valid) ls_rsp_n++;
        end
        @(posedge clk); #1;
        n_tests++;
        if (both || if_rsp_n != if_acc || ls_rsp_n != ls_acc) begin
            n_fail++;
            $display("FAIL contend_rsp both=%0d if_rsp=%0d/%0d ls_rsp=%0d/%0d want 0 and equal", both, if_rsp_n, if_acc, ls_rsp_n, ls_acc);
        end
    endtask

    task automatic test_reset_mid();
        bit rdy = 1'b0;
        int wait_c = 0, rsp_n = 0, ens = 0;
        if_req_valid = 1'b1; if_addr = 32'h80;
        while (!rdy && wait_c < 20) begin
            @(negedge clk);
            rdy = if_req_ready;
            wait_c++;
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (!rdy || mem_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_access acc=%0d en=%b busy=%b want 1/1/1", rdy, mem_en, busy);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL mid_reset_outs outs=%h want 0", all_outs); end
        last_ls = 1'b0;
        for (int k = 0; k < 2 * LAT + 4; k++) begin
            @(negedge clk);
            if (if_rsp_valid || ls_rsp_valid) rsp_n++;
            if (mem_en) ens++;
        end
        @(posedge clk); #1;
        n_tests++;
        if (rsp_n != 0 || ens != 0) begin
            n_fail++; $display("FAIL mid_reset_quiet rsp=%0d en=%0d want 0/0", rsp_n, ens);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int t = 0; t < 40; t++) begin
            bit is_ls = 1'($urandom_range(0, 1));
            bit we = is_ls && 1'($urandom_range(0, 1));
            logic [31:0] a = $urandom & 32'h3ff;
            logic [3:0] be = 4'($urandom_range(1, 15));
            logic [31:0] d = $urandom;
            logic [31:0] exp = we ? 32'h0 : ref_mem[a[9:2]];
            logic [3:0] exp_be = we ? be : 4'hf;
            txn(is_ls, we, a, be, d, o);
            if (we) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], be, d);
            n_tests++;
            if (o.lat !== LAT + 1 || o.ens !== LAT || !o.stable) begin
                n_fail++; $display("FAIL rand%0d_timing lat=%0d ens=%0d stable=%0d want %0d/%0d/1", t, o.lat, o.ens, o.stable, LAT + 1, LAT);
            end
            n_tests++;
            if (o.addr !== {a[31:2], 2'b00} || o.we !== we || o.be !== exp_be || (we && o.wdata !== d)) begin
                n_fail++;
                $display("FAIL rand%0d_bus addr=%h we=%b be=%b wd=%h want %h/%b/%b/%h", t, o.addr, o.we, o.be, o.wdata, {a[31:2], 2'b00}, we, exp_be, d);
            end
            n_tests++;
            if (o.rdata !== exp || o.other_rsp || o.rsp_after !== 1'b0) begin
                n_fail++; $display("FAIL rand%0d_data got %h other=%0d after=%b want %h/0/0", t, o.rdata, o.other_rsp, o.rsp_after, exp);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        @(posedge clk); #1;
        mem_loaded = 1'b1;
        test_reset();
        test_if_read();
        test_ls_store();
        test_align_withdraw();
        test_contention();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
